// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential multiplier family.
package mult_pkg;

    localparam int MULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/pp_and_row.sv
// One partial-product row: the operand gated by a single multiplier bit.
module pp_and_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] operand_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] row_o
);

    assign row_o = operand_i & {WIDTH{sel_i}};

endmodule

// File: rtl/seq_mult8_ctrl.sv
// Exact shift-and-add multiplier: one partial-product row accumulated per RUN cycle,
// product registered on the final step so it is visible together with done_o.
module seq_mult8_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH      = MULT_W,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = cnt_w(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    prod_q, prod_d;

    logic [WIDTH-1:0] row;
    logic [PW-1:0]    sum;
    logic [CW:0]      cnt_next;
    logic [WIDTH-1:0] remaining;
    logic             last_step;

    pp_and_row #(.WIDTH(WIDTH)) u_row (
        .operand_i (a_q),
        .sel_i     (b_q[cnt_q]),
        .row_o     (row)
    );

    assign sum = acc_q + ({{WIDTH{1'b0}}, row} << cnt_q);

    // One bit wider so that cnt+1 == WIDTH shifts every multiplier bit out.
    assign cnt_next  = {1'b0, cnt_q} + (CW+1)'(1);
    assign remaining = b_q >> cnt_next;
    assign last_step = (cnt_q == CW'(WIDTH-1)) || (EARLY_EXIT && (remaining == '0));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = multiplicand_i;
                    b_d     = multiplier_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                if (last_step) begin
                    prod_d  = sum;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign busy_o    = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign product_o = prod_q;

endmodule
